// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encodings and
// a helper that sizes the per-operation bit counter.
package serial_subtractor_pkg;

  // Encodings are fixed so other blocks and debug tooling can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..width-1 without wrapping inside an operation.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they match and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes A - B one bit per cycle, LSB
// first, over WIDTH cycles. D/Bout are registered and held between results.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             diff_bit;
  logic             borrow_bit;
  logic [WIDTH-1:0] r_next;

  // Per-bit cell works on the current LSBs and the running borrow.
  full_subtractor u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (borrow),
    .d   (diff_bit),
    .bout(borrow_bit)
  );

  // New difference bit enters at the MSB so the LSB ends up at bit 0.
  assign r_next = {diff_bit, r_sr[WIDTH-1:1]};

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so the shift registers and FSM update in lockstep.
    if (reset) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            r_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= r_next;
          borrow <= borrow_bit;
          if (cnt == LAST_BIT) begin
            // Publish the result on entry to DONE so it is valid with done.
            D     <= r_next;
            Bout  <= borrow_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while idle.
REQ-005 A  input  WIDTH  minuend; captured on the cycle start is accepted.
REQ-006 B  input  WIDTH  subtrahend; captured on the cycle start is accepted.
REQ-007 busy  output  1  high while the subtraction is in progress.
REQ-008 done  output  1  one-cycle pulse; D and Bout valid from this cycle on.
REQ-009 D  output  WIDTH  difference A-B modulo 2^WIDTH.
REQ-010 Bout  output  1  final borrow; 1 when A < B, unsigned.

Function
REQ-011 FSM states: IDLE, SHIFT, DONE; IDLE is the reset state.
REQ-012 IDLE: start=1 at an edge captures A and B into shift registers, clears the borrow register and the bit counter, and moves to SHIFT.
REQ-013 SHIFT: each cycle processes one bit, LSB first: diff = a0 XOR b0 XOR borrow; borrow_next = (~a0 & b0) | (~(a0 XOR b0) & borrow).
REQ-014 SHIFT: diff bit enters the result shift register at its MSB; the operand registers shift right by one.
REQ-015 SHIFT lasts exactly WIDTH cycles (counter 0..WIDTH-1), then moves to DONE.
REQ-016 DONE: D loads the result register, Bout loads the final borrow, done=1 for this cycle only, then returns to IDLE.
REQ-017 Latency: start accepted at edge k -> busy=1 for cycles k+1..k+WIDTH, done=1 in cycle k+WIDTH+1.
REQ-018 busy=1 exactly in SHIFT; done=1 exactly in DONE; busy and done are never high together.
REQ-019 start is ignored in SHIFT and DONE; no queuing, no effect on the running operation.
REQ-020 start held high continuously starts a new operation on the first IDLE cycle after DONE.
REQ-021 D and Bout hold their values from DONE until the next DONE; they do not change during a later SHIFT.
REQ-022 A and B may change freely after the capture edge without affecting the result.
REQ-023 Counter wrap: the counter is WIDTH-sized as clog2(WIDTH) bits or wider and never wraps within an operation.

Reset
REQ-024 reset=1 at any edge forces IDLE, busy=0, done=0, D=0, Bout=0, clears borrow, counter and shift registers.
REQ-025 reset during SHIFT or DONE aborts the operation; no done pulse follows.
REQ-026 reset has priority over start in the same cycle.

Structure
REQ-027 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) live in the team's shared constants include file, not local literals.
REQ-028 One sub-module: full_subtractor (inputs a, b, bin; outputs d, bout), instantiated once for the per-bit cell of REQ-013.
REQ-029 Borrow register, counter, shift registers and FSM are in serial_subtractor; no other sub-modules.

Verification (WIDTH=8)
REQ-030 A=0x35, B=0x12, start one cycle -> done in cycle 9 after the accept edge, D=0x23, Bout=0; busy high exactly 8 cycles.
REQ-031 A=0x12, B=0x35 -> D=0xDD, Bout=1; A=0x00, B=0x01 -> D=0xFF, Bout=1; A=0xFF, B=0xFF -> D=0x00, Bout=0.
REQ-032 start pulsed with A=0x10, B=0x01 during SHIFT of a running 0x35-0x12 operation -> ignored; single done, D=0x23.
REQ-033 reset asserted in the 4th SHIFT cycle -> next cycle busy=0, done=0, D=0, Bout=0; no done pulse within 20 following cycles.
REQ-034 start held high, A=0x80, B=0x01 -> back-to-back operations, done every 10 cycles, D=0x7F, Bout=0 each time.
REQ-035 Randomised self-check: 1000 random A, B pairs -> {Bout, D} equals the 9-bit value (A - B) mod 512, with Bout = (A < B).
